rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive cycles one requester holds the grant (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per channel; req[i] high = channel i wants the shared output.
REQ-005 w  input  4  data bit per channel; w[i] belongs to channel i.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 sel  output  2  index of the granted channel, registered; drives the 4:1 select.
REQ-008 valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 y  output  1  shared output, combinational: w[sel] when valid=1, else 0.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and GRANT (one channel owns y).
REQ-011 The block SHALL hold a 2-bit last-owner pointer and a 4-bit hold counter hcnt.
REQ-012 Priority search SHALL start at (last+1) mod 4 and rotate upward with wrap 3->0; the first channel with req high wins.
REQ-013 IDLE -> GRANT: at a rising edge with req non-zero, the winner per REQ-012 SHALL appear on gnt/sel/valid after that edge (1-cycle latency), with hcnt=1 and last=winner.
REQ-014 IDLE with req=0 SHALL stay IDLE; outputs remain gnt=0, sel unchanged, valid=0.
REQ-015 In GRANT, while req[sel]=1 and hcnt<MAX_HOLD, the grant SHALL be kept and hcnt incremented by 1 at each edge.
REQ-016 Release condition at an edge: req[sel]=0, or hcnt=MAX_HOLD.
REQ-017 On release, if any other channel requests, the next winner (REQ-012, search from sel+1, excluding sel) SHALL be granted at the same edge with no idle gap; hcnt=1.
REQ-018 On release by hcnt=MAX_HOLD with only req[sel] high, the same channel SHALL be regranted at that edge with hcnt=1.
REQ-019 On release with req=0, or with only the current owner requesting after it dropped req, the block SHALL go to IDLE: gnt=0, valid=0.
REQ-020 gnt SHALL always be zero or one-hot; gnt[sel]=1 whenever valid=1.
REQ-021 No channel SHALL wait more than 3*MAX_HOLD+1 cycles from req high (held) to its grant.
REQ-022 Requests changing mid-grant on non-owner channels SHALL NOT affect the current grant until release.
REQ-023 hcnt SHALL never exceed MAX_HOLD and SHALL NOT wrap.

Reset
REQ-024 While rst_n=0, asynchronously: state=IDLE, gnt=0, sel=0, valid=0, y=0, hcnt=0, last=3 (so channel 0 has first priority).
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately without waiting for a clock edge; after release, the first arbitration SHALL follow REQ-024 priority.
REQ-026 Reset deassertion SHALL take effect at the next rising edge; req sampled at that edge is arbitrated normally.

Verification
REQ-027 After reset, req=4'b1111 held, MAX_HOLD=4 -> sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; valid=1 throughout, no gap.
REQ-028 req=4'b0100 asserted for 2 cycles then 0 -> grant to 2 one cycle after assertion, valid high 2 cycles, then IDLE with gnt=0.
REQ-029 Only req[1] held for 10 cycles -> gnt=4'b0010 continuously, hcnt cycling 1..4, valid never drops.
REQ-030 Owner 0 granted, req[3] and req[1] rise, req[0] drops at hcnt=2 -> next grant is channel 1 (not 3) at that edge.
REQ-031 valid=1, sel=2, sweep w -> y equals w[2]; with valid=0 and w=4'b1111 -> y=0.
REQ-032 rst_n pulsed low between edges during GRANT -> gnt, valid, y go 0 immediately; after release with req=4'b1000 -> channel 3 granted next edge.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-channel round-robin arbiter with hold limit driving a shared 4:1 mux
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] w,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [1:0] last;
    logic [3:0] hcnt;

    logic       idleHit;
    logic [1:0] idleIdx;
    logic       relHit;
    logic [1:0] relIdx;
    logic       keepGrant;

    // First requester found walking upward from base+1, wrapping 3->0.
    function automatic logic [2:0] pickNext(input logic [3:0] r, input logic [1:0] base);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = base;
        for (int k = 1; k <= 4; k++) begin
            cand = base + 2'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {idleHit, idleIdx} = pickNext(req, last);
        // The current owner is masked out so a release hands over to someone else first.
        {relHit, relIdx}   = pickNext(req & ~(4'b0001 << sel), sel);
        keepGrant          = req[sel] && (hcnt < 4'(MAX_HOLD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            valid <= 1'b0;
            hcnt  <= 4'd0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (idleHit) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << idleIdx;
                        sel   <= idleIdx;
                        valid <= 1'b1;
                        hcnt  <= 4'd1;
                        last  <= idleIdx;
                    end
                end
                GRANT: begin
                    if (keepGrant) begin
                        hcnt <= hcnt + 4'd1;
                    end else if (relHit) begin
                        gnt  <= 4'b0001 << relIdx;
                        sel  <= relIdx;
                        hcnt <= 4'd1;
                        last <= relIdx;
                    end else if (req[sel]) begin
                        // Hold limit reached with nobody else waiting: regrant the owner.
                        hcnt <= 4'd1;
                    end else begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                        hcnt  <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                    hcnt  <= 4'd0;
                end
            endcase
        end
    end

    assign y = valid ? w[sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] w;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .w     (w),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wv [4];
    logic [1:0] expSel;

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        w     = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt",   32'(gnt),      32'h0);
        chk("rst_sel",   32'(sel),      32'h0);
        chk("rst_valid", 32'(valid),    32'h0);
        chk("rst_y",     32'(y),        32'h0);
        chk("rst_hcnt",  32'(dut.hcnt), 32'h0);
        chk("rst_last",  32'(dut.last), 32'h3);

        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;

        // All channels requesting: four cycles per owner, no gap.
        for (int t = 0; t < 17; t++) begin
            tick();
            expSel = 2'((t / 4) % 4);
            chk($sformatf("rr_sel_%0d", t),   32'(sel),   32'(expSel));
            chk($sformatf("rr_gnt_%0d", t),   32'(gnt),   32'(4'b0001 << expSel));
            chk($sformatf("rr_valid_%0d", t), 32'(valid), 32'h1);
        end

        req = 4'b0000;
        tick();
        chk("idle_gnt",   32'(gnt),   32'h0);
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_sel",   32'(sel),   32'h0);
        w = 4'b1111;
        #1;
        chk("idle_y", 32'(y), 32'h0);

        // Single channel 2 for two edges, with a mux sweep while it owns y.
        req = 4'b0100;
        tick();
        chk("c2_gnt",   32'(gnt),   32'h4);
        chk("c2_sel",   32'(sel),   32'h2);
        chk("c2_valid", 32'(valid), 32'h1);
        wv[0] = 4'b0000; wv[1] = 4'b0100; wv[2] = 4'b1011; wv[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            w = wv[i];
            #1;
            chk($sformatf("mux_y_%0d", i), 32'(y), 32'(i % 2));
        end
        tick();
        chk("c2_hold_valid", 32'(valid), 32'h1);
        chk("c2_hold_gnt",   32'(gnt),   32'h4);
        req = 4'b0000;
        tick();
        chk("c2_end_gnt",   32'(gnt),   32'h0);
        chk("c2_end_valid", 32'(valid), 32'h0);

        // Lone requester: regranted at each hold limit, never dropping valid.
        req = 4'b0010;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk($sformatf("solo_gnt_%0d", t),   32'(gnt),      32'h2);
            chk($sformatf("solo_valid_%0d", t), 32'(valid),    32'h1);
            chk($sformatf("solo_hcnt_%0d", t),  32'(dut.hcnt), 32'((t % 4) + 1));
        end
        req = 4'b0000;
        tick();
        chk("solo_end_valid", 32'(valid), 32'h0);

        // Owner 0 drops early while 1 and 3 wait: 1 wins by rotation.
        req = 4'b0001;
        tick();
        chk("o0_sel", 32'(sel), 32'h0);
        req = 4'b1011;
        tick();
        chk("o0_hold_sel",  32'(sel),      32'h0);
        chk("o0_hold_hcnt", 32'(dut.hcnt), 32'h2);
        req = 4'b1010;
        tick();
        chk("o0_next_sel",   32'(sel),   32'h1);
        chk("o0_next_gnt",   32'(gnt),   32'h2);
        chk("o0_next_valid", 32'(valid), 32'h1);

        // Asynchronous reset mid-grant, then channel 3 alone.
        w = 4'b1111;
        #1;
        chk("pre_rst_y", 32'(y), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",   32'(gnt),   32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_y",     32'(y),     32'h0);
        chk("arst_sel",   32'(sel),   32'h0);
        req = 4'b1000;
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_sel",   32'(sel),   32'h3);
        chk("post_rst_gnt",   32'(gnt),   32'h8);
        chk("post_rst_valid", 32'(valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
